// File: rtl/risc16_pkg.sv
// Shared definitions for the multi-cycle RiSC-16 core: opcodes, FSM states
// and instruction field helpers.
package risc16_pkg;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_ADDI = 3'b001;
   localparam logic [2:0] OP_NAND = 3'b010;
   localparam logic [2:0] OP_LUI  = 3'b011;
   localparam logic [2:0] OP_SW   = 3'b100;
   localparam logic [2:0] OP_LW   = 3'b101;
   localparam logic [2:0] OP_BEQ  = 3'b110;
   localparam logic [2:0] OP_JALR = 3'b111;

   typedef enum logic [2:0] {
      FETCH = 3'd0,
      LATCH = 3'd1,
      EXEC  = 3'd2,
      MEM   = 3'd3,
      WB    = 3'd4,
      HALT  = 3'd5
   } state_e;

   function automatic logic [2:0] get_op(input logic [15:0] ir);
      return ir[15:13];
   endfunction

   function automatic logic [2:0] get_ra(input logic [15:0] ir);
      return ir[12:10];
   endfunction

   function automatic logic [2:0] get_rb(input logic [15:0] ir);
      return ir[9:7];
   endfunction

   function automatic logic [2:0] get_rc(input logic [15:0] ir);
      return ir[2:0];
   endfunction

   // 7-bit signed immediate widened to the datapath width
   function automatic logic [15:0] sext7(input logic [15:0] ir);
      return {{9{ir[6]}}, ir[6:0]};
   endfunction

   function automatic logic [9:0] get_imm10(input logic [15:0] ir);
      return ir[9:0];
   endfunction

endpackage

// File: rtl/risc16_regfile.sv
// 8x16 register file: r0 reads as zero and ignores writes, two operand read
// ports plus a debug read port, one write port.
module risc16_regfile (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        we_i,
   input  logic [2:0]  waddr_i,
   input  logic [15:0] wdata_i,
   input  logic [2:0]  raddr_a_i,
   output logic [15:0] rdata_a_o,
   input  logic [2:0]  raddr_b_i,
   output logic [15:0] rdata_b_o,
   input  logic [2:0]  raddr_d_i,
   output logic [15:0] rdata_d_o
);

   logic [15:0] regs_q [1:7];
   logic [15:0] rf     [8];

   // r0 is a constant; only r1..r7 hold state
   assign rf[0] = '0;
   for (genvar g = 1; g < 8; g++) begin : g_view
      assign rf[g] = regs_q[g];
   end

   // register write, r0 never matches a storage slot
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 1; i < 8; i++) regs_q[i] <= '0;
      end else begin
         for (int i = 1; i < 8; i++) begin
            if (we_i && (waddr_i == 3'(i))) regs_q[i] <= wdata_i;
         end
      end
   end

   assign rdata_a_o = rf[raddr_a_i];
   assign rdata_b_o = rf[raddr_b_i];
   assign rdata_d_o = rf[raddr_d_i];

endmodule

// File: rtl/risc16_mc_core.sv
// Multi-cycle RiSC-16 core. FETCH/LATCH/EXEC for every instruction; loads and
// stores add MEM (wait for gnt) and loads add WB (wait for rvalid).
module risc16_mc_core
   import risc16_pkg::*;
#(
   parameter int unsigned PC_W     = 8,
   parameter int unsigned DMEM_AW  = 8,
   parameter int unsigned RESET_PC = 0
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic [PC_W-1:0]    imem_addr,
   input  logic [15:0]        imem_rdata,
   output logic               dmem_req,
   output logic               dmem_we,
   output logic [DMEM_AW-1:0] dmem_addr,
   output logic [15:0]        dmem_wdata,
   input  logic               dmem_gnt,
   input  logic               dmem_rvalid,
   input  logic [15:0]        dmem_rdata,
   output logic               retire,
   output logic               halted,
   output logic [PC_W-1:0]    pc_o,
   input  logic [2:0]         dbg_raddr,
   output logic [15:0]        dbg_rdata
);

   state_e               state_q, state_d;
   logic [PC_W-1:0]      pc_q, pc_d;
   logic [15:0]          ir_q, ir_d;
   logic [DMEM_AW-1:0]   ea_q, ea_d;
   logic [15:0]          wd_q, wd_d;

   logic [2:0]           op, ra, rb, rc;
   logic [15:0]          simm;
   logic [9:0]           imm10;

   logic [2:0]           rf_raddr_b;
   logic [15:0]          rf_rdata_a, rf_rdata_b;
   logic                 rf_we;
   logic [15:0]          rf_wdata;

   logic [PC_W-1:0]      pc_inc;
   logic                 use_rc;

   assign op    = get_op(ir_q);
   assign ra    = get_ra(ir_q);
   assign rb    = get_rb(ir_q);
   assign rc    = get_rc(ir_q);
   assign simm  = sext7(ir_q);
   assign imm10 = get_imm10(ir_q);

   // Port A always reads rb. Port B reads rc for the two register-register
   // ALU ops and ra otherwise (BEQ compare, SW store data).
   assign use_rc     = (op == OP_ADD) || (op == OP_NAND);
   assign rf_raddr_b = use_rc ? rc : ra;

   assign pc_inc = pc_q + PC_W'(1);

   risc16_regfile u_rf (
      .clk       (clk),
      .rst_n     (rst_n),
      .we_i      (rf_we),
      .waddr_i   (ra),
      .wdata_i   (rf_wdata),
      .raddr_a_i (rb),
      .rdata_a_o (rf_rdata_a),
      .raddr_b_i (rf_raddr_b),
      .rdata_b_o (rf_rdata_b),
      .raddr_d_i (dbg_raddr),
      .rdata_d_o (dbg_rdata)
   );

   // architectural state and latched memory operands
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FETCH;
         pc_q    <= PC_W'(RESET_PC);
         ir_q    <= '0;
         ea_q    <= '0;
         wd_q    <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         ea_q    <= ea_d;
         wd_q    <= wd_d;
      end
   end

   // next-state, register writeback and retire pulse
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      ir_d     = ir_q;
      ea_d     = ea_q;
      wd_d     = wd_q;
      rf_we    = 1'b0;
      rf_wdata = '0;
      retire   = 1'b0;

      unique case (state_q)
         FETCH: state_d = LATCH;

         LATCH: begin
            ir_d    = imem_rdata;
            state_d = EXEC;
         end

         EXEC: begin
            // common single-pass completion; memory ops and halt override
            state_d = FETCH;
            pc_d    = pc_inc;
            retire  = 1'b1;
            unique case (op)
               OP_ADD: begin
                  rf_we    = 1'b1;
                  rf_wdata = rf_rdata_a + rf_rdata_b;
               end
               OP_ADDI: begin
                  rf_we    = 1'b1;
                  rf_wdata = rf_rdata_a + simm;
               end
               OP_NAND: begin
                  rf_we    = 1'b1;
                  rf_wdata = ~(rf_rdata_a & rf_rdata_b);
               end
               OP_LUI: begin
                  rf_we    = 1'b1;
                  rf_wdata = {imm10, 6'b0};
               end
               OP_BEQ: begin
                  if (rf_rdata_a == rf_rdata_b) pc_d = pc_inc + PC_W'(simm);
               end
               OP_JALR: begin
                  if (simm != '0) begin
                     state_d = HALT;
                     pc_d    = pc_q;
                     retire  = 1'b0;
                  end else begin
                     // target comes from the pre-write read, so ra == rb works
                     rf_we    = 1'b1;
                     rf_wdata = 16'(pc_inc);
                     pc_d     = PC_W'(rf_rdata_a);
                  end
               end
               default: begin
                  // SW / LW: capture operands so the bus stays stable in MEM
                  ea_d    = DMEM_AW'(rf_rdata_a + simm);
                  wd_d    = rf_rdata_b;
                  state_d = MEM;
                  pc_d    = pc_q;
                  retire  = 1'b0;
               end
            endcase
         end

         MEM: begin
            if (dmem_gnt) begin
               if (op == OP_SW) begin
                  pc_d    = pc_inc;
                  retire  = 1'b1;
                  state_d = FETCH;
               end else begin
                  state_d = WB;
               end
            end
         end

         WB: begin
            // only a response after the grant cycle is taken
            if (dmem_rvalid) begin
               rf_we    = 1'b1;
               rf_wdata = dmem_rdata;
               pc_d     = pc_inc;
               retire   = 1'b1;
               state_d  = FETCH;
            end
         end

         HALT: state_d = HALT;

         default: state_d = FETCH;
      endcase
   end

   assign imem_addr  = pc_q;
   assign pc_o       = pc_q;
   assign halted     = (state_q == HALT);
   assign dmem_req   = (state_q == MEM);
   assign dmem_we    = (state_q == MEM) && (op == OP_SW);
   assign dmem_addr  = ea_q;
   assign dmem_wdata = wd_q;

endmodule

// File: tb/tb_risc16_mc_core.sv
// Lockstep bench: an instruction-level model runs alongside the core and is
// compared at every retire; a randomized data-memory responder adds waits.
module tb_risc16_mc_core;

   localparam int PC_W    = 8;
   localparam int DMEM_AW = 8;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic [PC_W-1:0]    imem_addr;
   logic [15:0]        imem_rdata;
   logic               dmem_req, dmem_we;
   logic [DMEM_AW-1:0] dmem_addr;
   logic [15:0]        dmem_wdata;
   logic               dmem_gnt = 1'b0, dmem_rvalid = 1'b0;
   logic [15:0]        dmem_rdata = '0;
   logic               retire, halted;
   logic [PC_W-1:0]    pc_o;
   logic [2:0]         dbg_raddr = '0;
   logic [15:0]        dbg_rdata;

   risc16_mc_core #(.PC_W(PC_W), .DMEM_AW(DMEM_AW), .RESET_PC(0)) dut (
      .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
      .dmem_rdata(dmem_rdata), .retire(retire), .halted(halted), .pc_o(pc_o),
      .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
   );

   always #50 clk = ~clk;

   logic [15:0] imem [256];
   logic [15:0] dmem [256];
   always @(posedge clk) imem_rdata <= imem[imem_addr];

   int cyc = 0;
   always @(posedge clk) cyc++;

   int n_chk = 0, n_pass = 0;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
   endtask

   // instruction encoders
   function automatic logic [15:0] ri(input int op, input int ra, input int rb, input int s);
      return {3'(op), 3'(ra), 3'(rb), 7'(s)};
   endfunction
   function automatic logic [15:0] rrr(input int op, input int ra, input int rb, input int rc);
      return {3'(op), 3'(ra), 3'(rb), 4'b0, 3'(rc)};
   endfunction
   function automatic logic [15:0] lui(input int ra, input int imm);
      return {3'b011, 3'(ra), 10'(imm)};
   endfunction

   // ---------------- instruction-level reference model ----------------
   int          m_regs [8];
   int          m_pc;
   bit          m_halt;
   int          m_op;
   logic [15:0] m_mem [256];

   task automatic m_step();
      int ir, ra, rb, rc, s, nxt, v, ea;
      bit w;
      ir = int'(imem[m_pc]);
      m_op = (ir >> 13) & 7; ra = (ir >> 10) & 7; rb = (ir >> 7) & 7; rc = ir & 7;
      s = ir & 127; if (s >= 64) s -= 128;
      nxt = (m_pc + 1) & 255; w = 0; v = 0;
      ea = (m_regs[rb] + s) & 255;
      case (m_op)
         0: begin w = 1; v = m_regs[rb] + m_regs[rc]; end
         1: begin w = 1; v = m_regs[rb] + s; end
         2: begin w = 1; v = ~(m_regs[rb] & m_regs[rc]); end
         3: begin w = 1; v = (ir & 1023) << 6; end
         4: m_mem[ea] = 16'(m_regs[ra]);
         5: begin w = 1; v = int'(m_mem[ea]); end
         6: if (m_regs[ra] == m_regs[rb]) nxt = (m_pc + 1 + s) & 255;
         default: begin
            if (s != 0) begin m_halt = 1; nxt = m_pc; end
            else begin w = 1; v = nxt; nxt = m_regs[rb] & 255; end
         end
      endcase
      if (w && ra != 0) m_regs[ra] = v & 16'hFFFF;
      m_pc = nxt;
   endtask

   // ---------------- data memory responder ----------------
   int fix_gw = -1, fix_rw = -1, cur_gw = 0, cur_rw = 0, gcnt = 0, rcnt = 0;
   int last_gw = 0, last_rw = 0, stray_n = 0, rsp_st = 0;
   logic [DMEM_AW-1:0] sv_addr, rd_addr, st_addr;
   logic [15:0]        sv_wdata, st_data;
   logic               sv_we;

   function automatic int pick(input int f);
      return (f >= 0) ? f : int'($urandom_range(0, 3));
   endfunction

   initial forever begin
      @(negedge clk);
      dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 16'($urandom);
      if (!rst_n) begin
         rsp_st = 0; gcnt = 0; cur_gw = pick(fix_gw); cur_rw = pick(fix_rw);
      end else if (stray_n > 0) begin
         stray_n--; dmem_rvalid = 1'b1;
      end else if (rsp_st == 1) begin
         if (rcnt >= cur_rw) begin
            dmem_rvalid = 1'b1; dmem_rdata = dmem[rd_addr];
            last_rw = rcnt; rsp_st = 0; cur_rw = pick(fix_rw);
         end else rcnt++;
      end else if (dmem_req) begin
         if (gcnt == 0) begin sv_addr = dmem_addr; sv_we = dmem_we; sv_wdata = dmem_wdata; end
         if (gcnt >= cur_gw) begin
            dmem_gnt = 1'b1; last_gw = gcnt;
            if (gcnt > 0) begin
               chk("hold_addr", dmem_addr, sv_addr);
               chk("hold_we", dmem_we, sv_we);
               chk("hold_wdata", dmem_wdata, sv_wdata);
            end
            if (dmem_we) begin
               dmem[dmem_addr] = dmem_wdata; st_addr = dmem_addr; st_data = dmem_wdata;
            end else begin
               rsp_st = 1; rcnt = 0; rd_addr = dmem_addr;
            end
            if ($urandom_range(0, 3) == 0) dmem_rvalid = 1'b1;  // must be ignored
            gcnt = 0; cur_gw = pick(fix_gw);
         end else gcnt++;
      end else if ($urandom_range(0, 15) == 0) begin
         dmem_rvalid = 1'b1;                                  // stray, ignored
      end
   end

   // ---------------- helpers ----------------
   int last = 0;

   task automatic sweep();
      for (int r = 0; r < 8; r++) begin
         dbg_raddr = 3'(r); #1;
         chk($sformatf("r%0d", r), dbg_rdata, m_regs[r]);
      end
   endtask

   task automatic dbg_chk(input string tag, input int r, input int exp);
      dbg_raddr = 3'(r); #1;
      chk(tag, dbg_rdata, exp);
   endtask

   task automatic do_reset(input int stray);
      @(negedge clk); #3 rst_n = 1'b0;
      @(negedge clk); #3;
      m_pc = 0; m_halt = 0;
      for (int i = 0; i < 8; i++) m_regs[i] = 0;
      for (int i = 0; i < 256; i++) m_mem[i] = dmem[i];
      chk("rst_pc", pc_o, 0); chk("rst_iaddr", imem_addr, 0);
      chk("rst_req", dmem_req, 0); chk("rst_we", dmem_we, 0);
      chk("rst_retire", retire, 0); chk("rst_halted", halted, 0);
      sweep();
      @(negedge clk); #3;
      stray_n = stray;
      rst_n = 1'b1; last = cyc - 1;
   endtask

   task automatic run(input int n);
      int k, t, lat, exp_lat;
      k = 0;
      while (k < n && !m_halt) begin
         t = 0;
         do begin @(negedge clk); #2; t++; end while (!retire && !halted && t < 60);
         if (!retire && !halted) begin chk("retire_wait", retire, 1); return; end
         m_step();
         if (halted) begin
            chk("halt", halted, m_halt);
            for (int i = 0; i < 20; i++) begin
               @(negedge clk); #2;
               chk("frz_retire", retire, 0); chk("frz_iaddr", imem_addr, m_pc);
               chk("frz_pc", pc_o, m_pc); chk("frz_halted", halted, 1);
            end
            return;
         end
         lat = cyc - last; last = cyc;
         exp_lat = (m_op == 4) ? 4 + last_gw : (m_op == 5) ? 5 + last_gw + last_rw : 3;
         chk("halt", halted, m_halt);
         chk("latency", lat, exp_lat);
         @(negedge clk); #2;
         chk("pc", pc_o, m_pc);
         sweep();
         k++;
      end
   endtask

   task automatic clear_imem();
      for (int i = 0; i < 256; i++) imem[i] = '0;
   endtask

   initial begin
      #50_000_000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1);
   end

   // ---------------- directed and random programs ----------------
   initial begin
      int t;
      logic [15:0] w;
      for (int i = 0; i < 256; i++) dmem[i] = 16'($urandom);

      // ALU, LUI/NAND, SW/LW with wait states, halt
      clear_imem();
      imem[0] = ri(1, 1, 0, 5);   imem[1] = ri(1, 2, 1, -1);  imem[2] = rrr(0, 3, 1, 2);
      imem[3] = ri(1, 0, 0, 7);   imem[4] = lui(1, 10'h3FF);  imem[5] = rrr(2, 2, 1, 1);
      imem[6] = ri(1, 1, 0, 16);  imem[7] = lui(2, 10'h2FB);  imem[8] = ri(1, 2, 2, 47);
      imem[9] = ri(4, 2, 1, 2);   imem[10] = ri(5, 4, 1, 2);  imem[11] = ri(7, 0, 0, 1);
      fix_gw = 3; fix_rw = 1;
      do_reset(0);
      run(3);
      dbg_chk("A_r1", 1, 5); dbg_chk("A_r2", 2, 4); dbg_chk("A_r3", 3, 9);
      run(1); dbg_chk("A_r0", 0, 0);
      run(2); dbg_chk("A_lui", 1, 16'hFFC0); dbg_chk("A_nand", 2, 16'h003F);
      run(3); run(1);
      chk("A_sw_addr", st_addr, 8'h12); chk("A_sw_data", st_data, 16'hBEEF);
      run(1); dbg_chk("A_lw", 4, 16'hBEEF);
      run(1);

      // BEQ taken/not taken and PC wrap
      clear_imem();
      imem[0] = ri(1, 1, 0, 15);  imem[1] = ri(1, 2, 0, 16);
      imem[2] = ri(1, 3, 3, 1);   imem[3] = ri(1, 3, 3, 1);
      imem[4] = ri(1, 1, 1, 1);   imem[5] = ri(6, 1, 2, -2);
      imem[6] = ri(1, 5, 0, -1);  imem[7] = ri(7, 0, 5, 0);
      imem[255] = ri(1, 6, 0, 1);
      fix_gw = -1; fix_rw = -1;
      do_reset(0);
      run(5); run(1); chk("B_beq_eq", pc_o, 4);
      run(2); chk("B_beq_ne", pc_o, 6);
      run(2); chk("B_jalr_ff", pc_o, 255);
      run(1); chk("B_wrap", pc_o, 0);

      // JALR link and jump
      clear_imem();
      imem[0] = ri(1, 1, 0, 16);  imem[1] = ri(1, 3, 3, 1);  imem[2] = ri(1, 3, 3, 1);
      imem[3] = ri(7, 7, 1, 0);   imem[16] = ri(7, 0, 0, 1);
      do_reset(0);
      run(4); dbg_chk("C_link", 7, 4); chk("C_target", pc_o, 16);
      run(1);

      // reset while a store waits for its grant, then stray response
      clear_imem();
      imem[0] = ri(1, 1, 0, 16);  imem[1] = ri(4, 1, 1, 0);
      imem[2] = ri(5, 2, 1, 0);   imem[3] = ri(7, 0, 0, 1);
      fix_gw = 1000;
      do_reset(0);
      run(1);
      t = 0;
      while (!dmem_req && t < 10) begin @(negedge clk); #2; t++; end
      chk("D_req_up", dmem_req, 1);
      #1 rst_n = 1'b0; #1;
      chk("D_mid_req", dmem_req, 0); chk("D_mid_pc", pc_o, 0); chk("D_mid_iaddr", imem_addr, 0);
      fix_gw = 0;
      do_reset(2);
      run(10);

      // random programs
      for (int p = 0; p < 4; p++) begin
         for (int i = 0; i < 256; i++) begin
            w = 16'($urandom);
            if (w[15:13] == 3'b111 && $urandom_range(0, 7) != 0) w[6:0] = '0;
            imem[i] = w;
         end
         do_reset(0);
         run(150);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/risc16_mc_core.md
Name: risc16_mc_core

Overview:
- Multi-cycle RiSC-16 core implementing the full 8-opcode ISA, including SW, BEQ, JALR and halt.
- Supersedes the fixed 8-bit-PC, load/ALU-only core.
- Instruction memory and data memory are both external.
- Data memory uses a req/gnt/rvalid handshake, so the core tolerates wait states.
- Sits between the instruction ROM/RAM and the shared data-memory arbiter.

Parameters:
- PC_W, 8: PC width; instruction address space is 2^PC_W words.
- DMEM_AW, 8: data address width; the effective address is truncated to its low DMEM_AW bits.
- RESET_PC, 0: PC value loaded on reset.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- imem_addr  out  PC_W  fetch address; memory is synchronous-read with 1-cycle latency
- imem_rdata  in  16  instruction word
- dmem_req  out  1  data request
- dmem_we  out  1  1 = store, 0 = load
- dmem_addr  out  DMEM_AW  data address
- dmem_wdata  out  16  store data
- dmem_gnt  in  1  request accepted
- dmem_rvalid  in  1  load data valid
- dmem_rdata  in  16  load data
- retire  out  1  1-cycle pulse per completed instruction
- halted  out  1  core halted
- pc_o  out  PC_W  current PC
- dbg_raddr  in  3  debug register select
- dbg_rdata  out  16  regs[dbg_raddr], combinational; r0 reads 0

Behaviour:
- Reset (async assert, sync deassert):
  - state = FETCH, pc = RESET_PC, ir = 0, regs r1..r7 = 0.
  - All outputs 0, except pc_o = RESET_PC and imem_addr = RESET_PC.
  - dmem_req falls immediately on assertion, even mid-transaction.
  - An outstanding response arriving after reset is ignored.
- Encoding:
  - opcode = ir[15:13], ra = [12:10], rb = [9:7], rc = [2:0].
  - simm7 = [6:0], sign-extended to 16 bits; imm10 = [9:0].
- Opcodes: ADD 000, ADDI 001, NAND 010, LUI 011, SW 100, LW 101, BEQ 110, JALR 111.
- States:
  - FETCH: imem_addr = pc. Go to LATCH.
  - LATCH: ir <= imem_rdata. Go to EXEC.
  - EXEC, by opcode:
    - ADD: regs[ra] <= rb + rc.
    - ADDI: regs[ra] <= rb + simm7.
    - NAND: regs[ra] <= ~(rb & rc).
    - LUI: regs[ra] <= {imm10, 6'b0}.
    - BEQ: pc <= pc + 1 + simm7 if regs[ra] == regs[rb], else pc + 1.
    - JALR with simm7 == 0: regs[ra] <= zero-extended pc + 1; pc <= regs[rb][PC_W-1:0]. The target uses the pre-write rb, so ra == rb is legal.
    - JALR with simm7 != 0: go to HALT, no retire.
    - SW/LW: latch ea = (regs[rb] + simm7)[DMEM_AW-1:0] and wdata = regs[ra]. Go to MEM.
    - Every other opcode: pc <= pc + 1, retire = 1, go to FETCH.
  - MEM:
    - dmem_req = 1; dmem_we/addr/wdata are held stable until and including the gnt cycle.
    - On gnt with SW: pc + 1, retire, go to FETCH.
    - On gnt with LW: go to WB.
  - WB:
    - Wait for dmem_rvalid. rvalid in the gnt cycle itself is not accepted.
    - On rvalid: regs[ra] <= dmem_rdata, pc + 1, retire, go to FETCH.
  - HALT: halted = 1. Nothing changes; only reset exits.
- Arithmetic and edge rules:
  - All arithmetic is mod 2^16; PC arithmetic is mod 2^PC_W, so pc = 2^PC_W-1 wraps to 0.
  - Writes to r0 are discarded, and r0 always reads 0.
  - Latency: ALU/BEQ/JALR take 3 cycles; SW takes 4+gnt_wait; LW takes 5+gnt_wait+rvalid_wait.
  - dmem_rvalid outside WB is ignored.

Decomposition:
- Package risc16_pkg:
  - opcode localparams;
  - state enum {FETCH, LATCH, EXEC, MEM, WB, HALT};
  - field-extract and sign-extend functions.
- Sub-module risc16_regfile:
  - 8x16;
  - three combinational read ports (rb, rc/ra, dbg);
  - one write port;
  - r0 hardwired to 0;
  - async reset.

Test Plan:
- ALU sequence: ADDI r1,r0,5; ADDI r2,r1,-1; ADD r3,r1,r2 -> r1=5, r2=4, r3=9; 3 retire pulses within 9 cycles; ADDI r0,r0,7 leaves r0=0.
- LUI and NAND: LUI r1,0x3FF -> r1=0xFFC0; NAND r2,r1,r1 -> r2=0x003F.
- Store and load with wait states:
  - Setup: r1=0x10, r2=0xBEEF; SW r2,r1,+2 with gnt delayed 3 cycles.
  - Expected SW: dmem_req held 4 cycles, addr=0x12, wdata=0xBEEF, we=1.
  - Then LW r4,r1,+2 with rvalid 2 cycles after gnt, rdata=0xBEEF -> r4=0xBEEF.
- BEQ:
  - Equal operands at pc=5 with simm7=-2 -> pc=4.
  - Unequal operands -> pc=6.
  - ADDI at pc=255 (PC_W=8) -> pc=0.
- JALR and halt:
  - JALR r7,r1 with r1=0x0010 at pc=3 -> r7=4, pc=0x10.
  - JALR with simm7=1 -> halted=1, pc_o frozen, no retire, imem_addr constant for 20 cycles.
- Reset mid-operation:
  - Drop rst_n while in MEM with dmem_req=1 -> dmem_req=0 in the same cycle, pc_o=RESET_PC.
  - A stray dmem_rvalid after release changes no register.
  - Execution restarts from RESET_PC.
